// File: rtl/pos_limit_tracker.sv
// Position integrator for the up/down motor FSM: prescales motor-on cycles into
// position steps, saturates at the travel limits and drives Up_Max/Dn_Max/fault.
// Build option: define LIMIT_HYST_EN to add release hysteresis (HYST steps) on the limit flags.
//
// state   | meaning
// IDLE    | no motor command
// MOV_UP  | UP_M alone, prescaler counting toward a +1 step
// MOV_DN  | DN_M alone, prescaler counting toward a -1 step
// FAULT   | both commands seen; left only after a cycle with both low
module pos_limit_tracker #(
    parameter int POS_W     = 8,
    parameter int MIN_POS   = 0,
    parameter int MAX_POS   = 200,
    parameter int RESET_POS = 0,
    parameter int STEP_DIV  = 4,
    parameter int HYST      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             UP_M,
    input  logic             DN_M,
    input  logic             load,
    input  logic [POS_W-1:0] load_val,
    output logic [POS_W-1:0] pos,
    output logic             Up_Max,
    output logic             Dn_Max,
    output logic             fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_UP    = 2'd1;
    localparam logic [1:0] S_DN    = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    localparam logic [POS_W-1:0] MIN_P   = POS_W'(MIN_POS);
    localparam logic [POS_W-1:0] MAX_P   = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] RESET_P = POS_W'(RESET_POS);

`ifdef LIMIT_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif
    // With zero hysteresis the hold window is empty and the flags reduce to plain compares.
    localparam int HYST_EFF = HYST_ON ? HYST : 0;
    localparam int UP_REL   = MAX_POS - HYST_EFF;
    localparam int DN_REL   = MIN_POS + HYST_EFF;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] div_base;
    logic [POS_W-1:0] pos_next;
    logic             up_next;
    logic             dn_next;
    int               lv_i;
    int               pos_next_i;

    always_comb begin
        state_next = S_IDLE;
        if (state == S_FAULT) begin
            state_next = (UP_M || DN_M) ? S_FAULT : S_IDLE;
        end else begin
            case ({UP_M, DN_M})
                2'b10:   state_next = S_UP;
                2'b01:   state_next = S_DN;
                2'b11:   state_next = S_FAULT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pos_next = pos;
        div_next = '0;
        div_base = '0;
        lv_i     = int'(load_val);
        if (load) begin
            if (lv_i > MAX_POS)
                pos_next = MAX_P;
            else if (lv_i < MIN_POS)
                pos_next = MIN_P;
            else
                pos_next = load_val;
        end else if (state_next == S_UP && pos != MAX_P) begin
            // A reversal restarts the count so the new direction sees the full latency.
            div_base = (state == S_UP) ? div_cnt : '0;
            if (div_base == DIV_LAST)
                pos_next = pos + POS_W'(1);
            else
                div_next = div_base + DIV_W'(1);
        end else if (state_next == S_DN && pos != MIN_P) begin
            div_base = (state == S_DN) ? div_cnt : '0;
            if (div_base == DIV_LAST)
                pos_next = pos - POS_W'(1);
            else
                div_next = div_base + DIV_W'(1);
        end
    end

    always_comb begin
        pos_next_i = int'(pos_next);
        up_next    = Up_Max;
        dn_next    = Dn_Max;
        if (pos_next_i == MAX_POS)
            up_next = 1'b1;
        else if (pos_next_i <= UP_REL)
            up_next = 1'b0;
        if (pos_next_i == MIN_POS)
            dn_next = 1'b1;
        else if (pos_next_i >= DN_REL)
            dn_next = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            pos     <= RESET_P;
            Up_Max  <= (RESET_POS == MAX_POS);
            Dn_Max  <= (RESET_POS == MIN_POS);
            fault   <= 1'b0;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            pos     <= pos_next;
            Up_Max  <= up_next;
            Dn_Max  <= dn_next;
            fault   <= (state_next == S_FAULT);
        end
    end

endmodule

// File: tb/tb_pos_limit_tracker.sv
// Bench for pos_limit_tracker: directed travel/limit/fault/reset steps, then random
// command traffic, all checked against a run-length model of the position rules.
module tb_pos_limit_tracker;

    localparam int MAXP = 200;
    localparam int MINP = 0;
    localparam int SDIV = 4;
    localparam int HY   = 2;
`ifdef LIMIT_HYST_EN
    localparam bit HYON = 1'b1;
`else
    localparam bit HYON = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_UP    = 1;
    localparam int M_DN    = 2;
    localparam int M_FAULT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       UP_M = 1'b0;
    logic       DN_M = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] pos;
    logic       Up_Max;
    logic       Dn_Max;
    logic       fault;

    int total = 0;
    int bad   = 0;

    int m_pos;
    int m_run;
    int m_mode;
    bit m_up;
    bit m_dn;

    pos_limit_tracker dut (
        .clk      (clk),
        .rst      (rst),
        .UP_M     (UP_M),
        .DN_M     (DN_M),
        .load     (load),
        .load_val (load_val),
        .pos      (pos),
        .Up_Max   (Up_Max),
        .Dn_Max   (Dn_Max),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_run  = 0;
        m_mode = M_IDLE;
        m_up   = (0 == MAXP);
        m_dn   = 1'b1;
    endtask

    // Run length counts consecutive edges of one commanded direction; every
    // SDIV-th such edge moves the position unless it is pinned at a limit.
    task automatic model_edge(input bit u, input bit d, input bit ld, input int lv);
        int nmode;
        if (m_mode == M_FAULT)
            nmode = (u || d) ? M_FAULT : M_IDLE;
        else if (u && d)
            nmode = M_FAULT;
        else if (u)
            nmode = M_UP;
        else if (d)
            nmode = M_DN;
        else
            nmode = M_IDLE;

        if (ld) begin
            m_pos = (lv > MAXP) ? MAXP : ((lv < MINP) ? MINP : lv);
            m_run = 0;
        end else if (nmode == M_UP || nmode == M_DN) begin
            int delta;
            delta = (nmode == M_UP) ? 1 : -1;
            if (m_pos + delta > MAXP || m_pos + delta < MINP) begin
                m_run = 0;
            end else begin
                m_run = (nmode == m_mode) ? m_run + 1 : 1;
                if (m_run == SDIV) begin
                    m_pos = m_pos + delta;
                    m_run = 0;
                end
            end
        end else begin
            m_run = 0;
        end
        m_mode = nmode;

        if (m_pos == MAXP) m_up = 1'b1;
        else if (!(HYON && m_pos > MAXP - HY)) m_up = 1'b0;
        if (m_pos == MINP) m_dn = 1'b1;
        else if (!(HYON && m_pos < MINP + HY)) m_dn = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pos"}, 32'(pos), 32'(m_pos));
        chk({tag, "_up"}, 32'(Up_Max), 32'(m_up));
        chk({tag, "_dn"}, 32'(Dn_Max), 32'(m_dn));
        chk({tag, "_fault"}, 32'(fault), 32'(m_mode == M_FAULT));
    endtask

    task automatic step(input string tag, input bit u, input bit d, input bit ld, input int lv);
        UP_M     = u;
        DN_M     = d;
        load     = ld;
        load_val = 8'(lv);
        @(posedge clk);
        model_edge(u, d, ld, lv);
        #1;
        check_all(tag);
    endtask

    task automatic steps(input string tag, input int n, input bit u, input bit d);
        for (int i = 0; i < n; i++) step(tag, u, d, 1'b0, 0);
    endtask

    // Pulses reset between edges and checks outputs before the next edge.
    task automatic async_reset(input string tag);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        UP_M = 1'b0;
        DN_M = 1'b0;
        load = 1'b0;
        rst  = 1'b0;
    endtask

    initial begin
        bit cu, cd;
        model_reset();

        // reset state
        #2;
        rst = 1'b1;
        #1;
        check_all("reset0");
        chk("reset0_pos_lit", 32'(pos), 0);
        chk("reset0_dn_lit", 32'(Dn_Max), 1);
        rst = 1'b0;

        // upward travel from 0 and prescale latency
        steps("up_a", 3, 1'b1, 1'b0);
        chk("up_e3_pos", 32'(pos), 0);
        step("up_e4", 1'b1, 1'b0, 1'b0, 0);
        chk("up_e4_pos", 32'(pos), 1);
        chk("up_e4_dn", 32'(Dn_Max), 0);
        steps("up_b", 4, 1'b1, 1'b0);
        chk("up_e8_pos", 32'(pos), 2);

        // reversal restarts the prescaler
        step("ld0", 1'b0, 1'b0, 1'b1, 0);
        steps("rev_up", 5, 1'b1, 1'b0);
        chk("rev_up_pos", 32'(pos), 1);
        steps("rev_dn", 3, 1'b0, 1'b1);
        chk("rev_dn3_pos", 32'(pos), 1);
        step("rev_dn4", 1'b0, 1'b1, 1'b0, 0);
        chk("rev_dn4_pos", 32'(pos), 0);
        chk("rev_dn4_dnmax", 32'(Dn_Max), 1);

        // upper limit and saturation
        step("ld199", 1'b0, 1'b0, 1'b1, 199);
        steps("top", 4, 1'b1, 1'b0);
        chk("top_pos", 32'(pos), 200);
        chk("top_upmax", 32'(Up_Max), 1);
        steps("sat", 12, 1'b1, 1'b0);
        chk("sat_pos", 32'(pos), 200);
        step("ld250", 1'b0, 1'b0, 1'b1, 250);
        chk("ld250_pos", 32'(pos), 200);
        steps("sat_dn", 8, 1'b0, 1'b1);

        // fault entry, hold and release
        step("ld50", 1'b0, 1'b0, 1'b1, 50);
        step("flt_both", 1'b1, 1'b1, 1'b0, 0);
        chk("flt_set", 32'(fault), 1);
        chk("flt_pos", 32'(pos), 50);
        steps("flt_dn", 6, 1'b0, 1'b1);
        chk("flt_hold", 32'(fault), 1);
        chk("flt_hold_pos", 32'(pos), 50);
        step("flt_ld", 1'b0, 1'b1, 1'b1, 60);
        chk("flt_ld_pos", 32'(pos), 60);
        step("flt_rel", 1'b0, 1'b0, 1'b0, 0);
        chk("flt_clr", 32'(fault), 0);

        // limit release from the top
        step("ld200", 1'b0, 1'b0, 1'b1, 200);
        steps("rel_a", 4, 1'b0, 1'b1);
        chk("rel_199_pos", 32'(pos), 199);
        chk("rel_199_up", 32'(Up_Max), 32'(HYON));
        steps("rel_b", 4, 1'b0, 1'b1);
        chk("rel_198_pos", 32'(pos), 198);
        chk("rel_198_up", 32'(Up_Max), 0);

        // reset in the middle of a prescale period
        step("ld10", 1'b0, 1'b0, 1'b1, 10);
        steps("mid", 2, 1'b1, 1'b0);
        async_reset("mid_rst");
        chk("mid_rst_pos", 32'(pos), 0);
        steps("post", 3, 1'b1, 1'b0);
        chk("post3_pos", 32'(pos), 0);
        step("post4", 1'b1, 1'b0, 1'b0, 0);
        chk("post4_pos", 32'(pos), 1);

        // random traffic
        cu = 1'b0;
        cd = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            int r;
            int lv;
            bit ld;
            r = int'($urandom_range(0, 99));
            if (r < 12) begin
                cu = 1'($urandom_range(0, 1));
                cd = 1'($urandom_range(0, 1));
                if (cu && cd && $urandom_range(0, 3) != 0) cd = 1'b0;
            end
            ld = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0:       lv = int'($urandom_range(0, 255));
                1:       lv = int'($urandom_range(195, 210));
                2:       lv = int'($urandom_range(0, 5));
                default: lv = int'($urandom_range(20, 180));
            endcase
            step("rnd", cu, cd, ld, lv);
            if ($urandom_range(0, 599) == 0) async_reset("rnd_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
